// File: rtl/fifo_pkg.sv
// Shared defaults, types and helpers for the FIFO read-side stream path.
package fifo_pkg;

   localparam int DWIDTH_DEF  = 8;
   localparam int PKT_LEN_DEF = 4;
   localparam int CNT_W_DEF   = 16;

   typedef logic [DWIDTH_DEF-1:0] fifo_word_t;
   typedef logic [1:0]            occ_t;

   // Words already owned by the stream side after this cycle's pop: buffered plus in flight.
   function automatic logic [2:0] credit_use(input occ_t occ, input logic inflight, input logic pop);
      return {1'b0, occ} + {2'b00, inflight} - {2'b00, pop};
   endfunction

endpackage

// File: rtl/fifo_skid_buf.sv
// Two-entry register buffer: head feeds the stream, tail catches the word arriving behind it.
module fifo_skid_buf
   import fifo_pkg::*;
#(
   parameter int DWIDTH = DWIDTH_DEF
) (
   input  logic              i_clk,
   input  logic              i_rst,
   input  logic              i_push,
   input  logic              i_pop,
   input  logic [DWIDTH-1:0] i_data,
   output occ_t              o_occ,
   output logic [DWIDTH-1:0] o_head
);

   occ_t              r_occ;
   logic [DWIDTH-1:0] r_head;
   logic [DWIDTH-1:0] r_tail;
   logic              w_pop;

   assign w_pop  = i_pop && (r_occ != 2'd0);
   assign o_occ  = r_occ;
   assign o_head = r_head;

   // A push alongside a pop lands in whichever slot becomes the new tail of the queue.
   always_ff @(posedge i_clk or negedge i_rst) begin
      if (!i_rst) begin
         r_occ  <= 2'd0;
         r_head <= '0;
         r_tail <= '0;
      end else begin
         case ({i_push, w_pop})
            2'b10: begin
               if (r_occ == 2'd0) r_head <= i_data;
               else               r_tail <= i_data;
               r_occ <= r_occ + 2'd1;
            end
            2'b01: begin
               r_head <= r_tail;
               r_occ  <= r_occ - 2'd1;
            end
            2'b11: begin
               if (r_occ == 2'd2) begin
                  r_head <= r_tail;
                  r_tail <= i_data;
               end else begin
                  r_head <= i_data;
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: rtl/fifo_rd_stream.sv
// Drains a synchronous FIFO onto a valid/ready stream with packet framing and a word counter.
module fifo_rd_stream
   import fifo_pkg::*;
#(
   parameter int DWIDTH  = DWIDTH_DEF,
   parameter int PKT_LEN = PKT_LEN_DEF,
   parameter int CNT_W   = CNT_W_DEF
) (
   input  logic              i_clk,
   input  logic              i_rst,
   input  logic              i_enable,
   input  logic              i_fifo_empty,
   input  logic [DWIDTH-1:0] i_fifo_rdata,
   output logic              o_fifo_rd_en,
   output logic              o_m_valid,
   input  logic              i_m_ready,
   output logic [DWIDTH-1:0] o_m_data,
   output logic              o_m_last,
   output logic [CNT_W-1:0]  o_words_out
);

   localparam logic [15:0] LAST_BEAT = 16'(PKT_LEN - 1);

   occ_t             w_occ;
   logic             w_valid;
   logic             w_pop;
   logic             w_rd_en;
   logic [2:0]       w_credit;
   logic             r_inflight;
   logic [15:0]      r_beat;
   logic [CNT_W-1:0] r_words;

   fifo_skid_buf #(
      .DWIDTH (DWIDTH)
   ) u_skid (
      .i_clk  (i_clk),
      .i_rst  (i_rst),
      .i_push (r_inflight),
      .i_pop  (w_pop),
      .i_data (i_fifo_rdata),
      .o_occ  (w_occ),
      .o_head (o_m_data)
   );

   // A new read is only issued when the buffer is guaranteed a free slot when its data lands.
   always_comb begin
      w_valid  = (w_occ != 2'd0);
      w_pop    = w_valid && i_m_ready;
      w_credit = credit_use(w_occ, r_inflight, w_pop);
      w_rd_en  = i_rst && i_enable && !i_fifo_empty && (w_credit < 3'd2);
   end

   assign o_fifo_rd_en = w_rd_en;
   assign o_m_valid    = w_valid;
   assign o_m_last     = w_valid && (r_beat == LAST_BEAT);
   assign o_words_out  = r_words;

   always_ff @(posedge i_clk or negedge i_rst) begin
      if (!i_rst) begin
         r_inflight <= 1'b0;
         r_beat     <= '0;
         r_words    <= '0;
      end else begin
         r_inflight <= w_rd_en;
         if (w_pop) begin
            r_beat <= (r_beat == LAST_BEAT) ? 16'd0 : r_beat + 16'd1;
            if (r_words != {CNT_W{1'b1}}) r_words <= r_words + CNT_W'(1);
         end
      end
   end

endmodule

// File: doc/fifo_rd_stream.md
Name: fifo_rd_stream

Overview:
Downstream read-side controller for the synchronous FIFO. It drains the FIFO through its rd_en/empty/rdata port and presents the words on a valid/ready stream with packet framing (m_last every PKT_LEN words). A 2-entry skid buffer absorbs the FIFO's 1-cycle read latency, so throughput stays at 1 word/cycle under backpressure with no word lost or duplicated.

Parameters:
DWIDTH, 8, FIFO word and stream data width
PKT_LEN, 4, words per packet; m_last marks the PKT_LEN-th word (legal range 1..2^16-1)
CNT_W, 16, width of the saturating transferred-word counter

Ports:
clk  input  1  single clock, rising edge
rst  input  1  asynchronous, active-low reset (0 = reset)
enable  input  1  permits new FIFO reads; does not gate draining of already-fetched words
fifo_empty  input  1  FIFO empty flag
fifo_rdata  input  DWIDTH  FIFO read data, valid the cycle after an accepted rd_en
fifo_rd_en  output  1  FIFO read strobe
m_valid  output  1  stream data valid
m_ready  input  1  stream sink ready
m_data  output  DWIDTH  stream data (head of skid buffer)
m_last  output  1  last word of current packet, qualified by m_valid
words_out  output  CNT_W  total words transferred (m_valid && m_ready), saturating

Behaviour:
- Reset (rst low, async): skid buffer empties; m_valid=0, m_data=0, m_last=0, words_out=0, beat counter=0, inflight=0. fifo_rd_en is forced to 0 while rst is low.
- State:
  - occ: 0..2 words held in the skid buffer.
  - inflight: a registered copy of the previous cycle's fifo_rd_en.
  - beat: 0..PKT_LEN-1.
- pop = m_valid && m_ready.
- fifo_rd_en = enable && !fifo_empty && (occ + inflight - pop) < 2.
  - Combinational from m_ready, fifo_empty, enable and registered state.
  - Never asserted while fifo_empty=1, so the FIFO cannot underflow.
- Capture: when inflight=1, fifo_rdata is written to the buffer tail at the end of that cycle. This happens unconditionally; the credit rule guarantees a free slot.
- Latency: with the buffer empty, a word read at cycle N (fifo_rd_en high) gives m_valid high at cycle N+2.
- Throughput: with m_ready held at 1 and the FIFO non-empty, steady state is 1 word/cycle.
- m_valid = (occ != 0). m_data and m_last are held stable while m_valid && !m_ready.
- Ordering: strict FIFO order, with no drop and no duplication.
- Simultaneous capture and pop: occ stays unchanged and the head advances. Pop with no capture decrements occ; capture with no pop increments occ.
- m_last = m_valid && (beat == PKT_LEN-1).
  - On each pop, beat increments, wrapping to 0 after PKT_LEN-1.
  - PKT_LEN=1 gives m_last on every word.
- words_out increments on each pop and saturates at 2^CNT_W-1. It does not wrap.
- enable deasserted mid-stream:
  - No new fifo_rd_en.
  - An inflight word is still captured.
  - Buffered words still drain.
  - beat is preserved, so packet framing continues when enable is reasserted.
- Backpressure (m_ready=0): occ fills to 2, then fifo_rd_en stays 0 until a pop.
- Reset asserted mid-operation: all state clears immediately, including buffered and inflight words and a partial packet (beat). After release, framing restarts at beat 0.

Decomposition:
- Shared package fifo_pkg holds:
  - localparam DWIDTH_DEF = 8
  - typedef fifo_word_t = logic [DWIDTH-1:0]
  - PKT_LEN_DEF
- One sub-module, fifo_skid_buf: a 2-entry register buffer with push/pop, occ output and head data.
- Credit logic, beat counter and words_out counter stay in fifo_rd_stream.

Test Plan:
- Reset: hold rst=0 for 3 cycles with FIFO non-empty and m_ready=1 -> fifo_rd_en=0, m_valid=0, m_data=0, m_last=0, words_out=0 throughout.
- Streaming: FIFO preloaded with 0x11,0x22,0x33,0x44,0x55; enable=1; m_ready=1 -> first m_valid 2 cycles after the first fifo_rd_en, then m_data=0x11..0x55 on consecutive cycles, m_last=1 only with 0x44, words_out=5.
- Backpressure: 6 words in FIFO, m_ready=0 for 6 cycles -> exactly 2 fifo_rd_en pulses, occ=2, m_data=first word held stable. Release m_ready -> all 6 words out in order, no gaps after the first.
- Empty boundary: FIFO goes empty after 2 words with m_ready=1 -> fifo_rd_en never high while fifo_empty=1, m_valid drops after word 2. Refill with 1 word -> it emerges and beat continues (3rd word of packet).
- enable toggle: deassert enable in the cycle fifo_rd_en is high -> the inflight word still appears on m_data and no further reads occur. Reassert -> stream resumes in order.
- Async reset mid-packet: assert rst between clock edges after 2 words of a packet with occ=2 -> outputs clear without waiting for a clock edge. After release, the next word carries beat 0, and m_last appears on the 4th word.
